// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle between the sequencer, the instruction memory and decode.
// The master end is the sequencer; the slave end is the memory/pipeline environment.
interface fetch_sequencer_if;
   logic [7:0]  imem_addr;
   logic        imem_init;
   logic [15:0] imem_q;
   logic        stall;
   logic        branch_taken;
   logic [7:0]  branch_target;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        halted;

   modport master (
      output imem_addr, imem_init, instr, instr_pc, instr_valid, halted,
      input  imem_q, stall, branch_taken, branch_target
   );

   modport slave (
      input  imem_addr, imem_init, instr, instr_pc, instr_valid, halted,
      output imem_q, stall, branch_taken, branch_target
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: memory boot window, PC sequencing, IF/ID register,
// stall/branch handling and halt detection.
module fetch_sequencer #(
   parameter logic [7:0]  START_PC    = 8'd0,
   parameter int unsigned BOOT_CYCLES = 2,
   parameter logic [15:0] HALT_INSTR  = 16'hFFFF
) (
   input  logic              clk,
   input  logic              reset,
   fetch_sequencer_if.master bus
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  boot_cnt_q, boot_cnt_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic [7:0]  instr_pc_q, instr_pc_d;
   logic        valid_q, valid_d;
   logic        imem_init_o, halted_o;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_BOOT;
         boot_cnt_q <= 4'd0;
         pc_q       <= START_PC;
         instr_q    <= 16'd0;
         instr_pc_q <= 8'd0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      // NOTE: every next-state value defaults to "hold" so no path infers a latch.
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      case (state_q)
         S_BOOT: begin
            boot_cnt_d = boot_cnt_q + 4'd1;
            if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
         end
         S_RUN: begin
            // A redirect wins over stall: the wrong-path fetch is flushed either way.
            if (bus.branch_taken) begin
               pc_d    = bus.branch_target;
               valid_d = 1'b0;
            end else if (!bus.stall) begin
               instr_d    = bus.imem_q;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
               pc_d       = pc_q + 8'd1;
               if (bus.imem_q == HALT_INSTR) state_d = S_HALT;
            end
         end
         S_HALT: begin
            if (bus.branch_taken) begin
               state_d = S_RUN;
               pc_d    = bus.branch_target;
               valid_d = 1'b0;
            end else if (!bus.stall) begin
               valid_d = 1'b0;
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_comb begin
      imem_init_o = (state_q == S_BOOT);
      halted_o    = (state_q == S_HALT);
   end

   assign bus.imem_addr   = pc_q;
   assign bus.imem_init   = imem_init_o;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = valid_q;
   assign bus.halted      = halted_o;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a cycle-level behavioural model predicts
// the visible outputs after every edge; a monitor compares them against the DUT.
module tb_fetch_sequencer;

   localparam int          BOOT_CYCLES = 2;
   localparam logic [7:0]  START_PC    = 8'd0;
   localparam logic [15:0] HALT_INSTR  = 16'hFFFF;

   typedef struct {
      logic [7:0]  addr;
      logic        init;
      logic        halted;
      logic        valid;
      logic [15:0] instr;
      logic [7:0]  ipc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] mem [256];

   int total = 0;
   int bad   = 0;
   exp_t exp_q [$];

   // model state
   int          m_boot;
   int          m_pc;
   bit          m_halted;
   bit          m_valid;
   logic [15:0] m_instr;
   int          m_ipc;

   fetch_sequencer_if bus_if ();

   assign bus_if.imem_q = mem[bus_if.imem_addr];

   fetch_sequencer #(
      .START_PC   (START_PC),
      .BOOT_CYCLES(BOOT_CYCLES),
      .HALT_INSTR (HALT_INSTR)
   ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] rand_word(input bit allow_halt);
      logic [15:0] w;
      w = 16'($urandom);
      if (allow_halt && $urandom_range(11) == 0) w = HALT_INSTR;
      else if (w == HALT_INSTR) w = 16'h0000;
      return w;
   endfunction

   // Apply inputs, advance one edge, update the model and queue its prediction.
   task automatic step(input bit s, input bit b, input logic [7:0] t, input bit r);
      exp_t e;
      bus_if.stall         = s;
      bus_if.branch_taken  = b;
      bus_if.branch_target = t;
      rst                  = r;
      @(posedge clk);
      if (r) begin
         m_boot = BOOT_CYCLES; m_pc = START_PC; m_halted = 0;
         m_valid = 0; m_instr = 16'd0; m_ipc = 0;
      end else if (m_boot > 0) begin
         m_boot--;
      end else if (b) begin
         m_pc = t; m_valid = 0; m_halted = 0;
      end else if (s) begin
         // everything holds
      end else if (m_halted) begin
         m_valid = 0;
      end else begin
         m_instr = mem[m_pc];
         m_ipc   = m_pc;
         m_valid = 1;
         if (m_instr == HALT_INSTR) m_halted = 1;
         m_pc = (m_pc + 1) % 256;
      end
      e.addr   = 8'(m_pc);
      e.init   = (m_boot > 0);
      e.halted = m_halted;
      e.valid  = m_valid;
      e.instr  = m_instr;
      e.ipc    = 8'(m_ipc);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: compares the DUT against the oldest queued prediction each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mon imem_addr", bus_if.imem_addr, e.addr);
            check("mon imem_init", bus_if.imem_init, e.init);
            check("mon halted", bus_if.halted, e.halted);
            check("mon instr_valid", bus_if.instr_valid, e.valid);
            if (e.valid) begin
               check("mon instr", bus_if.instr, e.instr);
               check("mon instr_pc", bus_if.instr_pc, e.ipc);
            end
         end
      end
   end

   initial begin
      bus_if.stall = 1'b0;
      bus_if.branch_taken = 1'b0;
      bus_if.branch_target = 8'd0;
      for (int i = 0; i < 256; i++) mem[i] = rand_word(1'b0);

      // reset and boot window
      repeat (3) step(0, 0, 8'd0, 1);
      check("rst instr_valid", bus_if.instr_valid, 0);
      check("rst halted", bus_if.halted, 0);
      check("rst imem_addr", bus_if.imem_addr, 0);
      check("rst imem_init", bus_if.imem_init, 1);
      check("rst instr", bus_if.instr, 0);
      check("rst instr_pc", bus_if.instr_pc, 0);
      step(0, 1, 8'd77, 0);
      check("boot init 1", bus_if.imem_init, 1);
      step(1, 0, 8'd0, 0);
      check("boot init 2", bus_if.imem_init, 0);
      check("boot no valid", bus_if.instr_valid, 0);

      // sequential fetch
      for (int i = 0; i < 14; i++) begin
         step(0, 0, 8'd0, 0);
         check("seq instr_pc", bus_if.instr_pc, i);
         check("seq instr", bus_if.instr, mem[i]);
         check("seq valid", bus_if.instr_valid, 1);
      end

      // stall while instr_pc = 4
      step(0, 1, 8'd0, 0);
      check("br bubble", bus_if.instr_valid, 0);
      repeat (5) step(0, 0, 8'd0, 0);
      check("pre-stall pc", bus_if.instr_pc, 4);
      repeat (3) begin
         step(1, 0, 8'd0, 0);
         check("stall instr_pc", bus_if.instr_pc, 4);
         check("stall imem_addr", bus_if.imem_addr, 5);
      end
      step(0, 0, 8'd0, 0);
      check("post-stall pc", bus_if.instr_pc, 5);

      // branch with simultaneous stall at instr_pc = 9
      repeat (4) step(0, 0, 8'd0, 0);
      check("pre-branch pc", bus_if.instr_pc, 9);
      step(1, 1, 8'd2, 0);
      check("br+stall valid", bus_if.instr_valid, 0);
      step(0, 0, 8'd0, 0);
      check("br target pc", bus_if.instr_pc, 2);
      check("br target instr", bus_if.instr, mem[2]);
      check("br target valid", bus_if.instr_valid, 1);

      // PC wrap
      step(0, 1, 8'd254, 0);
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 8'd0, 0);
         check("wrap pc", bus_if.instr_pc, (254 + k) % 256);
      end

      // halt and wrong-path recovery
      mem[6] = HALT_INSTR;
      step(0, 1, 8'd4, 0);
      repeat (3) step(0, 0, 8'd0, 0);
      check("halt instr", bus_if.instr, 16'hFFFF);
      check("halt valid", bus_if.instr_valid, 1);
      check("halt halted", bus_if.halted, 1);
      step(1, 0, 8'd0, 0);
      check("halt stall valid", bus_if.instr_valid, 1);
      step(0, 0, 8'd0, 0);
      check("halt drop valid", bus_if.instr_valid, 0);
      check("halt pc", bus_if.imem_addr, 7);
      step(0, 0, 8'd0, 0);
      check("halt pc hold", bus_if.imem_addr, 7);
      check("halt still halted", bus_if.halted, 1);
      step(0, 1, 8'd3, 0);
      check("recover halted", bus_if.halted, 0);
      check("recover bubble", bus_if.instr_valid, 0);
      step(0, 0, 8'd0, 0);
      check("recover pc", bus_if.instr_pc, 3);
      check("recover valid", bus_if.instr_valid, 1);
      mem[6] = rand_word(1'b0);

      // reset mid-operation
      step(0, 0, 8'd0, 1);
      check("midrst valid", bus_if.instr_valid, 0);
      check("midrst init", bus_if.imem_init, 1);

      // randomized traffic
      for (int i = 0; i < 256; i++) mem[i] = rand_word(1'b1);
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(3) == 0) mem[$urandom_range(255)] = rand_word(1'b1);
         step($urandom_range(3) == 0, $urandom_range(9) == 0, 8'($urandom),
              $urandom_range(199) == 0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the 256 x 16-bit instruction memory. After reset it initialises the memory, then runs the program counter. Each fetched word is presented to decode through a registered IF/ID stage. Pipeline stalls and taken branches from downstream are honoured, and fetch stops on a halt instruction.

## Interface
- START_PC, 8'd0, PC value loaded on reset.
- BOOT_CYCLES, 2, number of cycles `imem_init` is held high after reset releases (range 1..15).
- HALT_INSTR, 16'hFFFF, instruction word that stops fetching.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  8  read address to instruction memory; equals the PC register (combinational).
- imem_init  out  1  memory load strobe; high whenever the FSM is in BOOT.
- imem_q  in  16  memory read data; combinational from `imem_addr`, valid in the same cycle.
- stall  in  1  decode cannot accept; hold PC and IF/ID.
- branch_taken  in  1  redirect PC; one-cycle pulse from execute.
- branch_target  in  8  redirect address; sampled only when `branch_taken` = 1.
- instr  out  16  IF/ID instruction register.
- instr_pc  out  8  address `instr` was fetched from.
- instr_valid  out  1  `instr` and `instr_pc` are a valid, non-flushed instruction.
- halted  out  1  FSM is in HALT.

## Operation
- FSM states are BOOT, RUN and HALT. Reset forces BOOT, PC = START_PC, boot counter = 0, instr = 0, instr_pc = 0, instr_valid = 0.
- **BOOT**
  - `imem_init` = 1.
  - The counter increments on every edge with reset low.
  - When the counter reaches BOOT_CYCLES-1, the FSM moves to RUN on that edge.
  - stall and branch_taken are ignored in BOOT.
- **RUN**, with priority branch_taken > stall > normal:
  - **branch_taken:** PC <= branch_target and instr_valid <= 0 (flush of the wrong-path fetch). This applies even if stall = 1.
  - **stall:** PC, instr, instr_pc and instr_valid all hold.
  - **normal:** instr <= imem_q, instr_pc <= PC, instr_valid <= 1, PC <= PC + 1 modulo 256 (255 wraps to 0).
  - **Halt:** if a normal capture loads imem_q == HALT_INSTR, the FSM moves to HALT on the same edge. The halt word is still presented with instr_valid = 1, and PC advances as usual.
- **HALT**
  - halted = 1 and PC holds.
  - If stall = 1, IF/ID holds, so the halt word stays visible.
  - Otherwise, on the first non-stalled edge, instr_valid <= 0 and remains 0.
  - branch_taken in HALT means the halt was wrong-path. The FSM returns to RUN with PC <= branch_target and instr_valid <= 0.
- **Reset mid-operation:** reset overrides everything on that edge. It re-enters BOOT and re-initialises memory. Any in-flight instruction is dropped.
- **Arithmetic:** the PC is a plain 8-bit register. There is no carry-out and no out-of-range detection.

## Timing
- imem_addr → imem_q → IF/ID register takes one cycle. Fetch latency is 1 cycle from PC to instr_valid.
- After the reset-release edge:
  - imem_init stays high for exactly BOOT_CYCLES cycles.
  - The first capture, mem[START_PC], happens on edge BOOT_CYCLES+1.
- Sustained throughput is one instruction per cycle when stall = 0.
- Branch penalty is one bubble. On the edge with branch_taken, instr_valid falls to 0. On the next edge, mem[target] is captured with instr_valid = 1, provided stall = 0.
- stall and branch_taken are sampled only at the rising edge. branch_target needs no hold beyond that edge.
- HALT entry is visible on `halted` one cycle after the halt word appears on imem_q.

## Test plan
- **Reset/boot:** with BOOT_CYCLES = 2, hold reset for 3 cycles, then release.
  - While reset is held: instr_valid = 0, halted = 0, imem_addr = 0.
  - imem_init is high during reset and for 2 cycles after release, then low.
  - The next edge gives instr = mem[0], instr_pc = 0, instr_valid = 1.
- **Sequential fetch:** load mem[0..13] and run 14 cycles. Expect instr_pc = 0,1,…,13 on consecutive cycles, each with the matching word, and instr_valid held at 1.
- **Stall:** assert stall for 3 cycles while instr_pc = 4. Expect instr_pc = 4 and imem_addr = 5 held for 3 cycles, then instr_pc = 5 on the first edge after stall drops.
- **Branch with simultaneous stall:** branch_taken = 1 with target 8'd2, stall = 1, while instr_pc = 9. Expect instr_valid = 0 on the next cycle, then instr_pc = 2 with mem[2] once stall is low.
- **Wrap:** branch to 8'd254 with mem[254..255] and mem[0] non-halt. Expect instr_pc sequence 254, 255, 0, 1.
- **Halt and wrong-path recovery:**
  - Place 16'hFFFF at mem[6]. Expect instr = FFFF with instr_valid = 1, halted = 1 from the next cycle, and instr_valid = 0 afterwards.
  - Then assert branch_taken with target 3. Expect halted = 0 and instr_pc = 3 after the one-bubble penalty.
